// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical memory port between instruction fetch and data access,
// one latched transaction at a time, with round-robin or fixed priority and a response watchdog.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MASK_W  = 2,
    parameter int RR_EN   = 1,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [MASK_W-1:0] i_wmask,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [MASK_W-1:0] d_wmask,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [MASK_W-1:0] pmem_wmask,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [DATA_W-1:0] pmem_wdata,
    input  logic [DATA_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              busy,
    output logic              timeout_err
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [MASK_W-1:0] cmd_wmask;
    logic              cmd_rd;
    logic              cmd_wr;
    logic              last_d;
    logic [CW-1:0]     wd_cnt;
    logic              i_req;
    logic              d_req;
    logic              pick_d;
    logic              wd_hit;

    always_comb begin
        i_req  = i_read | i_write;
        d_req  = d_read | d_write;
        // on conflict D wins unless round-robin says it was D's turn last
        pick_d = d_req & (~i_req | (RR_EN == 0) | ~last_d);
        wd_hit = (TIMEOUT != 0) && (wd_cnt == CW'(TIMEOUT - 1));
    end

    assign busy       = state != IDLE;
    assign pmem_read  = busy & cmd_rd;
    assign pmem_write = busy & cmd_wr;
    assign pmem_addr  = cmd_addr;
    assign pmem_wdata = cmd_wdata;
    assign pmem_wmask = cmd_wmask;
    assign i_resp     = (state == GRANT_I) & pmem_resp;
    assign d_resp     = (state == GRANT_D) & pmem_resp;
    assign i_rdata    = pmem_rdata;
    assign d_rdata    = pmem_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            cmd_wmask   <= '0;
            cmd_rd      <= 1'b0;
            cmd_wr      <= 1'b0;
            last_d      <= 1'b1;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (state == IDLE) begin
            if (i_req | d_req) begin
                state     <= pick_d ? GRANT_D : GRANT_I;
                last_d    <= pick_d;
                cmd_addr  <= pick_d ? d_addr : i_addr;
                cmd_wdata <= pick_d ? d_wdata : i_wdata;
                cmd_wmask <= pick_d ? d_wmask : i_wmask;
                cmd_wr    <= pick_d ? d_write : i_write;
                cmd_rd    <= pick_d ? d_read & ~d_write : i_read & ~i_write;
                wd_cnt    <= '0;
            end
        end else if (pmem_resp) begin
            state <= IDLE;
        end else begin
            if (wd_cnt != CW'(TIMEOUT))
                wd_cnt <= wd_cnt + 1'b1;
            if (wd_hit)
                timeout_err <= 1'b1;
        end
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single physical memory port between two requesters: instruction fetch (I) and data access (D).
- Sits between the CPU-side split ports (I-side and D-side, or their caches) and physical memory.
- Grants one transaction at a time and holds the grant until physical memory asserts resp.
- Includes fixed-priority or round-robin arbitration, command latching, and a response watchdog.

Parameters:
- ADDR_W, 16, address width (lc3b_word)
- DATA_W, 16, data width (lc3b_word)
- MASK_W, 2, byte-enable width (lc3b_mem_wmask)
- RR_EN, 1: 1 = round-robin on conflict; 0 = fixed priority, D wins
- TIMEOUT, 255: cycles in a grant without pmem_resp before timeout_err sets; 0 disables the watchdog

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- i_read  in  1  I-side read request
- i_write  in  1  I-side write request
- i_wmask  in  MASK_W  I-side byte enables
- i_addr  in  ADDR_W  I-side address
- i_wdata  in  DATA_W  I-side write data
- i_rdata  out  DATA_W  I-side read data
- i_resp  out  1  I-side completion
- d_read, d_write, d_wmask, d_addr, d_wdata, d_rdata, d_resp: same as I-side, for the D-side
- pmem_read  out  1  physical memory read strobe
- pmem_write  out  1  physical memory write strobe
- pmem_wmask  out  MASK_W  physical memory byte enables
- pmem_addr  out  ADDR_W  physical memory address
- pmem_wdata  out  DATA_W  physical memory write data
- pmem_rdata  in  DATA_W  physical memory read data
- pmem_resp  in  1  physical memory completion
- busy  out  1  grant active
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- A requester is requesting when read|write is high. Asserting both read and write is illegal; write wins.
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE:
  - No requests -> stay in IDLE.
  - Only I -> GRANT_I. Only D -> GRANT_D.
  - Both requesting -> RR_EN=1 grants the side opposite last_grant; RR_EN=0 grants D.
- On the IDLE->GRANT edge, latch the winner's addr, wdata, wmask and read/write into command registers, and set last_grant to the winner.
- In GRANT_x, pmem_* is driven from the latch only.
  - Latency: request seen in IDLE in cycle N -> pmem strobe high in cycle N+1.
  - Requester changes after the grant do not alter pmem_*.
- Completion:
  - pmem_resp in cycle M drives x_resp=1 combinationally in the same cycle M. The other side's resp stays 0.
  - Next state is IDLE; pmem_read and pmem_write are 0 from cycle M+1.
  - The requester must drop its request in M+1.
  - Minimum turnaround between back-to-back grants: one IDLE cycle.
- i_rdata and d_rdata = pmem_rdata at all times. Only resp qualifies the data.
- In IDLE, pmem_read=pmem_write=0, pmem_addr/wdata/wmask hold the last latched values, and both resp=0.
- A pmem_resp arriving in IDLE is ignored (no resp forwarded, no state change).
- busy = state != IDLE.
- Watchdog:
  - Counter clears on entry to GRANT and increments each GRANT cycle without pmem_resp; it saturates.
  - When it reaches TIMEOUT (TIMEOUT!=0), timeout_err sets and stays set until reset.
  - The grant is not aborted; the arbiter keeps waiting.
- Reset (rst_n=0 at a clock edge), including mid-transaction:
  - state=IDLE, pmem_read=pmem_write=0.
  - Command registers, pmem_addr/wdata/wmask = 0.
  - last_grant=D (I wins the first RR conflict).
  - Watchdog count=0, timeout_err=0, busy=0, resp outputs=0.
  - A pmem_resp in the cycle after reset is ignored.

Test Plan:
- Lone I read: i_read=1, i_addr=0x1234; pmem_resp after 3 cycles with rdata=0xBEEF -> pmem_read=1 and pmem_addr=0x1234 one cycle after request; i_resp=1 with i_rdata=0xBEEF in the resp cycle; d_resp=0 throughout.
- Conflict, RR_EN=1, from reset: i_read and d_write (d_addr=0x0040, d_wdata=0x00AA, d_wmask=2'b01) asserted together -> I served first. After its resp plus one IDLE cycle, D is granted with pmem_write=1, addr 0x0040, wdata 0x00AA, wmask 01. A second simultaneous pair -> I served first again (alternation).
- Conflict, RR_EN=0: three consecutive simultaneous I/D request pairs -> D is granted each time while both are asserted; I is granted only once D is idle.
- Latch stability: change d_addr 0x0040->0x0080 mid-grant -> pmem_addr stays 0x0040 until pmem_resp.
- Watchdog: TIMEOUT=4, withhold pmem_resp -> timeout_err=1 after 4 grant cycles; busy stays 1. A later pmem_resp completes normally, and timeout_err remains 1.
- Reset mid-grant: rst_n=0 while in GRANT_D -> next cycle pmem_write=0, busy=0, pmem_addr=0. A stray pmem_resp right after reset produces no d_resp. Then a simultaneous I/D request -> I is granted.
